// File: rtl/muldiv_if.sv
// Handshake and result bundle between a requester and the muldiv_unit.
interface muldiv_if;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_stop;
  logic        div_stop;
  logic        div_zero;
  logic        busy;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  hi, lo, mult_stop, div_stop, div_zero, busy
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output hi, lo, mult_stop, div_stop, div_zero, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 signed multiply / divide: magnitude shift-add and restoring
// division, one bit per clock, sign fixed up on the completing edge.
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  acc;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [W-1:0]    opnd;     // |multiplicand| or |divisor|
  logic            neg_lo;
  logic            neg_hi;
  logic [W-1:0]    hi_q, lo_q;
  logic            mult_stop_q, div_stop_q, div_zero_q, busy_q;
  logic            mult_stop_nxt, div_stop_nxt, div_zero_nxt;

  logic [W-1:0]    a_abs, b_abs;
  logic [W:0]      mul_add, mul_sum;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_sub;
  logic [2*W-1:0]  mul_res;
  logic [W-1:0]    quo_res, rem_res;

  assign a_abs = bus.op_a[W-1] ? W'(-bus.op_a) : bus.op_a;
  assign b_abs = bus.op_b[W-1] ? W'(-bus.op_b) : bus.op_b;

  assign mul_add = acc[0] ? {1'b0, opnd} : '0;
  assign mul_sum = (W+1)'({1'b0, acc[2*W-1:W]} + mul_add);

  // Remainder stays below the divisor, so the 32-bit difference is exact when div_ge.
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = W'(div_shift[W-1:0] - opnd);

  assign mul_res = neg_lo ? (2*W)'(-acc) : acc;
  assign quo_res = neg_lo ? W'(-acc[W-1:0]) : acc[W-1:0];
  assign rem_res = neg_hi ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mult_stop_q <= 1'b0;
      div_stop_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      mult_stop_q <= mult_stop_nxt;
      div_stop_q  <= div_stop_nxt;
      div_zero_q  <= div_zero_nxt;
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    mult_stop_nxt = 1'b0;
    div_stop_nxt  = 1'b0;
    div_zero_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mult_start) begin
          state_nxt = MULT;
        end else if (bus.div_start) begin
          if (bus.op_b == '0) begin
            state_nxt    = DONE;
            div_stop_nxt = 1'b1;
            div_zero_nxt = 1'b1;
          end else begin
            state_nxt = DIV;
          end
        end
      end
      MULT: begin
        if (count == '0) begin
          state_nxt     = DONE;
          mult_stop_nxt = 1'b1;
        end
      end
      DIV: begin
        if (count == '0) begin
          state_nxt    = DONE;
          div_stop_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mult_start) begin
            count  <= CW'(W);
            acc    <= {{W{1'b0}}, b_abs};
            opnd   <= a_abs;
            neg_lo <= bus.op_a[W-1] ^ bus.op_b[W-1];
            neg_hi <= bus.op_a[W-1] ^ bus.op_b[W-1];
          end else if (bus.div_start && bus.op_b != '0) begin
            count  <= CW'(W);
            acc    <= {{W{1'b0}}, a_abs};
            opnd   <= b_abs;
            neg_lo <= bus.op_a[W-1] ^ bus.op_b[W-1];
            neg_hi <= bus.op_a[W-1];
          end
        end
        MULT: begin
          if (count != '0) begin
            acc   <= {mul_sum, acc[W-1:1]};
            count <= CW'(count - 1'b1);
          end else begin
            hi_q <= mul_res[2*W-1:W];
            lo_q <= mul_res[W-1:0];
          end
        end
        DIV: begin
          if (count != '0) begin
            acc   <= div_ge ? {div_sub, acc[W-2:0], 1'b1}
                            : {div_shift[W-1:0], acc[W-2:0], 1'b0};
            count <= CW'(count - 1'b1);
          end else begin
            hi_q <= rem_res;
            lo_q <= quo_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mult_stop = mult_stop_q;
  assign bus.div_stop  = div_stop_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.busy      = busy_q;
endmodule
